// File: rtl/pilot_arb_pkg.sv
// Shared types and constants for the pilot command bus arbiter.
// PILOT_ARB_TROJAN_EN selects the benchmark trojan variant in the top.
package pilot_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam int ARB_W       = 20;
   localparam int TROJ_THRESH = 5;

endpackage

// File: rtl/pilot_cmd_arbiter_rr_pick.sv
// Combinational picker: requester 0 wins outright, others are scanned
// round-robin starting at rr_ptr_i and wrapping back to index 1.
module rr_pick #(
   parameter int NREQ = 3,
   localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   rr_ptr_i,
   output logic [IW-1:0]   winner_o,
   output logic            any_o
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      winner_o = '0;
      any_o    = |req_i;
      found    = req_i[0];
      idx      = '0;
      for (int k = 0; k < NREQ - 1; k++) begin
         idx = IW'(((int'(rr_ptr_i) - 1 + k) % (NREQ - 1)) + 1);
         if (!found && req_i[idx]) begin
            winner_o = idx;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pilot_cmd_arbiter.sv
// Failsafe-priority / round-robin arbiter for the shared actuator command bus.
// Optional benchmark trojan variant: define PILOT_ARB_TROJAN_EN.
module pilot_cmd_arbiter
   import pilot_arb_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int W        = ARB_W,
   parameter int HOLD_MAX = 15,
   parameter int TIMEOUT  = 63
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   done,
   input  logic [NREQ*W-1:0] cmd_in,
   input  logic              clr_err,
   output logic [NREQ-1:0]   gnt,
   output logic [W-1:0]      cmd_out,
   output logic              cmd_valid,
   output logic              busy,
   output logic              timeout_err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   winner_q, winner_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   hold_q, hold_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [W-1:0]    cmd_q, cmd_d;
   logic            vld_q, vld_d;
   logic            err_q, err_d;
   logic [IW-1:0]   pick;
   logic            any_req;
   logic            rel, tmo;
`ifdef PILOT_ARB_TROJAN_EN
   logic [2:0]      troj_q, troj_d;
`endif

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .winner_o (pick),
      .any_o    (any_req)
   );

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      rr_ptr_d = rr_ptr_q;
      hold_d   = hold_q;
      gnt_d    = '0;
      cmd_d    = '0;
      vld_d    = 1'b0;
      err_d    = clr_err ? 1'b0 : err_q;
      rel      = 1'b0;
      tmo      = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d  = GRANT;
               winner_d = pick;
               hold_d   = '0;
               gnt_d    = NREQ'(1) << pick;
               cmd_d    = cmd_in[int'(pick)*W +: W];
               vld_d    = 1'b1;
            end
         end
         GRANT: begin
            // Any single cause is enough; simultaneous causes still give one release.
            tmo = (hold_q == CW'(TIMEOUT));
            rel = done[winner_q] || !req[winner_q] ||
                  ((winner_q != '0) && req[0]) ||
                  ((hold_q >= CW'(HOLD_MAX)) && |(req & ~gnt_q)) || tmo;
            if (rel) begin
               state_d = RELEASE;
               if (tmo) err_d = 1'b1;
            end else begin
               gnt_d  = gnt_q;
               cmd_d  = cmd_in[int'(winner_q)*W +: W];
               vld_d  = 1'b1;
               hold_d = (hold_q == CW'(TIMEOUT)) ? hold_q : hold_q + CW'(1);
            end
         end
         RELEASE: begin
            state_d = IDLE;
            if (winner_q != '0)
               rr_ptr_d = (winner_q == IW'(NREQ - 1)) ? IW'(1) : winner_q + IW'(1);
         end
         default: state_d = IDLE;
      endcase
`ifdef PILOT_ARB_TROJAN_EN
      // Counts completed grants to the last requester; the grant after the threshold is muted.
      troj_d = troj_q;
      if (state_q == RELEASE && winner_q == IW'(NREQ - 1) && troj_q != 3'd7)
         troj_d = troj_q + 3'd1;
      if (vld_d && winner_d == IW'(NREQ - 1) && troj_q >= 3'(TROJ_THRESH))
         cmd_d = '0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         winner_q <= '0;
         rr_ptr_q <= IW'(1);
         hold_q   <= '0;
         gnt_q    <= '0;
         cmd_q    <= '0;
         vld_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         rr_ptr_q <= rr_ptr_d;
         hold_q   <= hold_d;
         gnt_q    <= gnt_d;
         cmd_q    <= cmd_d;
         vld_q    <= vld_d;
         err_q    <= err_d;
      end
   end

`ifdef PILOT_ARB_TROJAN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) troj_q <= '0;
      else     troj_q <= troj_d;
   end
`endif

   assign gnt         = gnt_q;
   assign cmd_out     = cmd_q;
   assign cmd_valid   = vld_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = err_q;

endmodule

// File: tb/tb_pilot_cmd_arbiter.sv
// Scoreboard bench for pilot_cmd_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the arbitration rules.
module tb_pilot_cmd_arbiter;

   localparam int NREQ     = 3;
   localparam int W        = 20;
   localparam int HOLD_MAX = 15;
   localparam int TIMEOUT  = 63;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ-1:0]   done = '0;
   logic [NREQ*W-1:0] cmd_in = '0;
   logic              clr_err = 1'b0;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      cmd_out;
   logic              cmd_valid;
   logic              busy;
   logic              timeout_err;

   pilot_cmd_arbiter #(.NREQ(NREQ), .W(W), .HOLD_MAX(HOLD_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .cmd_in      (cmd_in),
      .clr_err     (clr_err),
      .gnt         (gnt),
      .cmd_out     (cmd_out),
      .cmd_valid   (cmd_valid),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NREQ-1:0] gnt;
      logic [W-1:0]    cmd;
      logic            vld;
      logic            busy;
      logic            err;
   } exp_t;

   exp_t q[$];
   int   total  = 0;
   int   passed = 0;

   // Transaction-level model state
   int          holder = -1;   // requester currently owning the bus, -1 if none
   int          held   = 0;    // completed grant cycles of the current holder
   bit          dead   = 1'b0; // bus in its post-release gap cycle
   int          rr     = 1;    // where the round-robin scan starts
   bit          err    = 1'b0;
   logic [W-1:0] word  = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int choose(input logic [NREQ-1:0] r);
      if (r[0]) return 0;
      for (int k = 0; k < NREQ - 1; k++) begin
         int i = 1 + ((rr - 1 + k) % (NREQ - 1));
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      holder = -1; held = 0; dead = 1'b0; rr = 1; err = 1'b0; word = '0;
   endtask

   task automatic model_step();
      exp_t e;
      bit   new_err = err & ~clr_err;
      if (holder < 0 && !dead) begin
         int w = choose(req);
         if (w >= 0) begin
            holder = w; held = 0; word = cmd_in[w*W +: W];
         end
      end else if (holder >= 0) begin
         logic [NREQ-1:0] others = req & ~(NREQ'(1) << holder);
         bit stop = done[holder] || !req[holder] || (holder != 0 && req[0]) ||
                    (held >= HOLD_MAX && others != 0) || (held == TIMEOUT);
         if (held == TIMEOUT) new_err = 1'b1;
         if (stop) begin
            if (holder != 0) rr = (holder + 1 > NREQ - 1) ? 1 : holder + 1;
            holder = -1; dead = 1'b1;
         end else begin
            held = (held + 1 > TIMEOUT) ? TIMEOUT : held + 1;
            word = cmd_in[holder*W +: W];
         end
      end else begin
         dead = 1'b0;
      end
      err    = new_err;
      e.gnt  = (holder >= 0) ? NREQ'(1) << holder : '0;
      e.cmd  = (holder >= 0) ? word : '0;
      e.vld  = (holder >= 0);
      e.busy = (holder >= 0) || dead;
      e.err  = err;
      q.push_back(e);
   endtask

   task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d, input logic c);
      @(negedge clk);
      req = r; done = d; clr_err = c;
      for (int i = 0; i < NREQ; i++) cmd_in[i*W +: W] = W'($urandom);
      model_step();
   endtask

   task automatic cycn(input int n, input logic [NREQ-1:0] r);
      for (int i = 0; i < n; i++) cyc(r, '0, 1'b0);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #4;
      rst = 1'b1;
      #1;
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_cmd", 64'(cmd_out), 64'h0);
      chk("rst_vld", 64'(cmd_valid), 64'h0);
      @(posedge clk);
      #4;
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_err", 64'(timeout_err), 64'h0);
      @(negedge clk);
      req = '0; done = '0; clr_err = 1'b0;
      rst = 1'b0;
      model_reset();
   endtask

   // Monitor: pops one expectation per edge once stimulus has produced it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("gnt", 64'(gnt), 64'(e.gnt));
            chk("cmd_out", 64'(cmd_out), 64'(e.cmd));
            chk("cmd_valid", 64'(cmd_valid), 64'(e.vld));
            chk("busy", 64'(busy), 64'(e.busy));
            chk("timeout_err", 64'(timeout_err), 64'(e.err));
         end
      end
   end

   initial begin
      logic [NREQ-1:0] r, d;
      logic c;
      pulse_reset();
      // 1: single requester 1
      cycn(4, 3'b010);
      cycn(3, 3'b000);
      // 2: holder 1 with requester 2 pending, hold limit preemption then rr wrap
      cycn(22, 3'b110);
      cycn(3, 3'b000);
      // 3: holder 2 preempted by the failsafe
      cycn(5, 3'b100);
      cycn(6, 3'b101);
      cycn(3, 3'b000);
      // 4: watchdog timeout then clear
      cycn(TIMEOUT + 4, 3'b010);
      cyc(3'b000, 3'b000, 1'b1);
      cycn(3, 3'b000);
      // 5: done and failsafe request in the same cycle
      cycn(3, 3'b010);
      cyc(3'b011, 3'b010, 1'b0);
      cycn(5, 3'b001);
      cycn(3, 3'b000);
      // 6: reset mid-grant, then fresh arbitration
      cycn(3, 3'b100);
      pulse_reset();
      cycn(5, 3'b110);
      cycn(3, 3'b000);
      // random traffic
      r = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 1; i < NREQ; i++)
            if ($urandom_range(7) == 0) r[i] = ~r[i];
         if (!r[0]) r[0] = ($urandom_range(39) == 0);
         else       r[0] = ($urandom_range(3) != 0);
         d = '0;
         for (int i = 0; i < NREQ; i++) d[i] = ($urandom_range(15) == 0);
         c = ($urandom_range(49) == 0);
         cyc(r, d, c);
      end
      cycn(4, 3'b000);
      @(posedge clk);
      #3;
      chk("queue_drained", 64'(q.size()), 64'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/pilot_cmd_arbiter.md
Name: pilot_cmd_arbiter

Overview:
Shares one 20-bit actuator command bus (y-vector width of the pilot controller) between NREQ requesting controllers, e.g. autopilot FSM, manual override and failsafe.
- Requester 0 is the failsafe and has absolute priority; the others are served round-robin.
- Grants are bounded by a hold limit, with a watchdog timeout.
- Sits between the pilot FSM instances and the actuator drivers.

Parameters:
NREQ, 3, number of requesters (2..8); index 0 is the priority requester
W, 20, command word width
HOLD_MAX, 15, grant cycles after which a pending competitor preempts the holder
TIMEOUT, 63, grant cycles without done and without competitors before a watchdog release

Ports:
clk  in  1  clock; all state updates on the posedge
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  request level per requester; held high while bus is wanted
done  in  NREQ  one-cycle pulse from the current holder ending its transaction
cmd_in  in  NREQ*W  command words, requester i at bits [i*W +: W]
clr_err  in  1  synchronous clear of timeout_err
gnt  out  NREQ  one-hot grant, registered
cmd_out  out  W  registered copy of the granted requester's cmd_in; 0 when no grant
cmd_valid  out  1  high exactly while gnt is non-zero
busy  out  1  high in GRANT and RELEASE
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: all outputs are 0, state is IDLE, rr_ptr=1, hold_cnt=0, winner=0.
- FSM states: IDLE, GRANT, RELEASE (2-bit encoding).
- IDLE:
  - If any req bit is set, the winner is picked combinationally: req[0] wins if set; otherwise the first set req[i] scanning from rr_ptr upward through NREQ-1 and wrapping to 1.
  - At the next edge: gnt=onehot(winner), state GRANT, hold_cnt=0.
  - Latency from req sampled high to gnt high is 1 cycle.
- GRANT:
  - Each edge: cmd_out<=cmd_in[winner], cmd_valid=1, hold_cnt increments and saturates at TIMEOUT.
  - cmd_out trails cmd_in by 1 cycle; the first valid word appears in the first GRANT cycle (registered at the IDLE->GRANT edge).
- Release conditions, evaluated every GRANT cycle; any one true moves to RELEASE at the next edge:
  - a) done[winner]=1
  - b) req[winner]=0
  - c) winner!=0 and req[0]=1 (failsafe preemption, regardless of hold_cnt)
  - d) hold_cnt>=HOLD_MAX and some other req bit is set
  - e) hold_cnt==TIMEOUT; this also sets timeout_err=1
- Multiple release conditions in the same cycle produce a single release. timeout_err is set only if (e) is true.
- RELEASE: one dead cycle with gnt=0, cmd_out=0, cmd_valid=0.
  - rr_ptr updates to winner+1, wrapping NREQ->1.
  - If winner==0, rr_ptr is unchanged.
  - Next state is IDLE; consecutive grants are therefore separated by at least 2 cycles (RELEASE then IDLE).
- done pulses from non-holders are ignored. done arriving together with the grant edge is honoured in the following GRANT cycle only if still high.
- timeout_err:
  - Cleared by rst, or by clr_err at the next edge.
  - If set and clear occur together, set wins.
- Reset asserted mid-grant: gnt and cmd_out drop to 0 immediately (asynchronous); no RELEASE cycle.
- req changing inside RELEASE or IDLE has no effect until arbitration in IDLE.

Optional Feature:
PILOT_ARB_TROJAN_EN: benchmark trojan variant.
- With the macro: a 3-bit saturating counter increments on each grant to requester NREQ-1. Once it reaches 5, cmd_out for that requester is forced to 0 while gnt and cmd_valid still behave normally. The counter is cleared only by rst.
- Without the macro: no counter exists, and the behaviour is exactly as in Behaviour.

Decomposition:
- Package pilot_arb_pkg holds:
  - state enum {IDLE, GRANT, RELEASE}
  - default widths (W=20)
  - the trojan threshold constant TROJ_THRESH=5
- Sub-module rr_pick: purely combinational round-robin picker (req, rr_ptr -> winner index, any). It is instantiated once.

Test Plan:
1. Reset, then req=3'b010 -> gnt=3'b010 after 1 edge; cmd_out=cmd_in[1] from the next cycle; cmd_valid=1.
2. Holder 1, req[2] pending, no done -> release at hold_cnt=15, one dead cycle, then gnt=3'b100; rr_ptr wraps to 1.
3. Holder 2 at hold_cnt=4, req[0] asserted -> RELEASE next edge, gnt=3'b001 two cycles later; rr_ptr stays 0-independent.
4. Single requester 1, never pulses done -> after 63 grant cycles timeout_err=1 and gnt=0; clr_err pulse -> timeout_err=0.
5. done[1] and req[0] asserted in the same cycle while holder is 1 -> exactly one RELEASE, then grant 0.
6. rst pulsed mid-grant -> gnt, cmd_out and cmd_valid=0 asynchronously; after release, req=3'b110 -> gnt=3'b010. With PILOT_ARB_TROJAN_EN, the sixth grant to requester 2 gives cmd_out=0.
